// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with bubble insertion and halt drain sequencer.
// Optional hazard stall counter built when STALL_COUNTER_EN is defined.
module id_ex_pipe_reg #(
    parameter int CTRL_W     = 12,
    parameter int HALT_DRAIN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_is_halt,
    input  logic              is_hazard,
    input  logic              flush,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_is_halt,
    output logic              halt_pending,
    output logic              is_halted,
    output logic [31:0]       stall_count
);
    localparam int BW = 145 + CTRL_W;
    localparam int CW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   ex_q, ex_d;
    logic            load;

    // Only IDLE admits new instructions; DRAIN and HALTED both force bubbles.
    assign load = (state_q == IDLE) && !flush && !is_hazard && id_valid;
    assign ex_d = load ? {1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm,
                          id_rs1, id_rs2, id_rd, id_ctrl, id_is_halt} : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && load && id_is_halt) begin
            state_d = DRAIN;
            cnt_d   = '0;
        end else if (state_q == DRAIN) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(HALT_DRAIN - 1)) ? HALTED : DRAIN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

    assign {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
            ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_is_halt} = ex_q;
    assign halt_pending = (state_q == DRAIN);
    assign is_halted    = (state_q == HALTED);

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_q <= '0;
        else if (is_hazard && !flush && state_q != HALTED && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: table-driven vectors through a scoreboard queue plus async reset sequences.
module tb_id_ex_pipe_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0, id_is_halt = 1'b0, is_hazard = 1'b0, flush = 1'b0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [11:0] id_ctrl = '0;
    logic        ex_valid, ex_is_halt, halt_pending, is_halted;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, stall_count;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [11:0] ex_ctrl;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.CTRL_W(12), .HALT_DRAIN(3)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .id_is_halt(id_is_halt), .is_hazard(is_hazard), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_is_halt(ex_is_halt),
        .halt_pending(halt_pending), .is_halted(is_halted), .stall_count(stall_count)
    );

    typedef struct {
        logic        v, hz, fl, ih;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [11:0] ctrl;
        logic        ev, eih, ep, eh;
        logic [31:0] epc;
        logic [4:0]  erd;
        logic [11:0] ectrl;
        logic [31:0] es;
    } vec_t;

    typedef struct {
        logic [156:0] bundle;
        logic [1:0]   st;
        logic [31:0]  sc;
        int           idx;
    } exp_t;

    vec_t vt[14];
    exp_t sb[$];

    function automatic logic [156:0] mk_bundle(logic v, logic [31:0] pc, logic [4:0] rd,
                                               logic [11:0] ctrl, logic ih);
        logic [4:0] r1, r2;
        r1 = rd + 5'd1;
        r2 = rd + 5'd2;
        return v ? {1'b1, pc, pc ^ 32'h1111_0000, pc ^ 32'h2222_0000, pc + 32'd4,
                    r1, r2, rd, ctrl, ih} : '0;
    endfunction

    function automatic logic [156:0] got_bundle();
        return {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_is_halt};
    endfunction

    function automatic logic [31:0] exp_stall(logic [31:0] s);
`ifdef STALL_COUNTER_EN
        return s;
`else
        return 32'd0 & s;
`endif
    endfunction

    task automatic chk(string nm, int idx, logic [156:0] got, logic [156:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic check_all_zero(string nm);
        chk({nm, "_bundle"}, 0, got_bundle(), '0);
        chk({nm, "_status"}, 0, {155'd0, halt_pending, is_halted}, '0);
        chk({nm, "_stall"}, 0, {125'd0, stall_count}, '0);
    endtask

    task automatic apply(vec_t t, int idx);
        exp_t e, g;
        id_valid    = t.v;
        is_hazard   = t.hz;
        flush       = t.fl;
        id_is_halt  = t.ih;
        id_pc       = t.pc;
        id_rd       = t.rd;
        id_ctrl     = t.ctrl;
        id_rs1_data = t.pc ^ 32'h1111_0000;
        id_rs2_data = t.pc ^ 32'h2222_0000;
        id_imm      = t.pc + 32'd4;
        id_rs1      = t.rd + 5'd1;
        id_rs2      = t.rd + 5'd2;
        e.bundle = mk_bundle(t.ev, t.epc, t.erd, t.ectrl, t.eih);
        e.st     = {t.ep, t.eh};
        e.sc     = exp_stall(t.es);
        e.idx    = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("bundle", g.idx, got_bundle(), g.bundle);
        chk("halt_status", g.idx, {155'd0, halt_pending, is_halted}, {155'd0, g.st});
        chk("stall_count", g.idx, {125'd0, stall_count}, {125'd0, g.sc});
    endtask

    initial begin
        //        v  hz fl ih pc            rd ctrl    ev eih ep eh epc           erd ectrl   es
        vt[0]  = '{1, 0, 0, 0, 32'h10, 5'd5, 12'h003, 1, 0, 0, 0, 32'h10, 5'd5, 12'h003, 32'd0};
        vt[1]  = '{1, 1, 0, 0, 32'h14, 5'd6, 12'h001, 0, 0, 0, 0, 32'h0,  5'd0, 12'h000, 32'd1};
        vt[2]  = '{1, 0, 0, 0, 32'h14, 5'd6, 12'h001, 1, 0, 0, 0, 32'h14, 5'd6, 12'h001, 32'd1};
        vt[3]  = '{1, 1, 1, 0, 32'h18, 5'd7, 12'h002, 0, 0, 0, 0, 32'h0,  5'd0, 12'h000, 32'd1};
        vt[4]  = '{1, 0, 0, 0, 32'h1C, 5'd8, 12'h007, 1, 0, 0, 0, 32'h1C, 5'd8, 12'h007, 32'd1};
        vt[5]  = '{0, 0, 0, 0, 32'h20, 5'd9, 12'h001, 0, 0, 0, 0, 32'h0,  5'd0, 12'h000, 32'd1};
        vt[6]  = '{1, 0, 1, 1, 32'h24, 5'd0, 12'h000, 0, 0, 0, 0, 32'h0,  5'd0, 12'h000, 32'd1};
        vt[7]  = '{1, 1, 0, 1, 32'h24, 5'd0, 12'h000, 0, 0, 0, 0, 32'h0,  5'd0, 12'h000, 32'd2};
        vt[8]  = '{1, 0, 0, 1, 32'h24, 5'd0, 12'h000, 1, 1, 1, 0, 32'h24, 5'd0, 12'h000, 32'd2};
        vt[9]  = '{1, 0, 0, 0, 32'h28, 5'd9, 12'h001, 0, 0, 1, 0, 32'h0,  5'd0, 12'h000, 32'd2};
        vt[10] = '{1, 0, 1, 0, 32'h2C, 5'd3, 12'h001, 0, 0, 1, 0, 32'h0,  5'd0, 12'h000, 32'd2};
        vt[11] = '{1, 0, 0, 0, 32'h2C, 5'd3, 12'h001, 0, 0, 0, 1, 32'h0,  5'd0, 12'h000, 32'd2};
        vt[12] = '{1, 1, 0, 0, 32'h30, 5'd4, 12'h001, 0, 0, 0, 1, 32'h0,  5'd0, 12'h000, 32'd2};
        vt[13] = '{1, 0, 0, 0, 32'h34, 5'd4, 12'h005, 0, 0, 0, 1, 32'h0,  5'd0, 12'h000, 32'd2};

        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) apply(vt[i], i);

        #1 reset = 1'b0;
        #1 check_all_zero("reset_from_halted");
        reset = 1'b1;

        apply('{1, 0, 0, 0, 32'h40, 5'd2, 12'h005, 1, 0, 0, 0, 32'h40, 5'd2, 12'h005, 32'd0}, 20);
        #1 reset = 1'b0;
        #1 check_all_zero("async_reset_midrun");
        reset = 1'b1;

        apply('{1, 0, 0, 1, 32'h50, 5'd0, 12'h000, 1, 1, 1, 0, 32'h50, 5'd0, 12'h000, 32'd0}, 21);
        apply('{1, 0, 0, 0, 32'h54, 5'd1, 12'h001, 0, 0, 1, 0, 32'h0,  5'd0, 12'h000, 32'd0}, 22);
        #1 reset = 1'b0;
        #1 check_all_zero("async_reset_middrain");
        reset = 1'b1;
        apply('{1, 0, 0, 0, 32'h58, 5'd1, 12'h001, 1, 0, 0, 0, 32'h58, 5'd1, 12'h001, 32'd0}, 23);
        apply('{1, 0, 0, 0, 32'h5C, 5'd2, 12'h003, 1, 0, 0, 0, 32'h5C, 5'd2, 12'h003, 32'd0}, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
